// File: rtl/mult_pkg.sv
// Shared types and default widths for the multiplier/accumulator result path.
// Read by acc_sat_add and product_accumulator.
package mult_pkg;

    localparam int OP_W       = 32;
    localparam int PROD_W_DEF = 2 * OP_W;
    localparam int ACC_W_DEF  = 72;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    typedef logic [PROD_W_DEF-1:0] prod_t;
    typedef logic [ACC_W_DEF-1:0]  acc_t;

endpackage : mult_pkg

// File: rtl/acc_sat_add.sv
// Accumulator adder: ACC_W-bit sum of the running total and a product, with carry out.
// When PRODUCT_ACC_SATURATE_EN is defined, a carry clamps the sum to all-ones.
module acc_sat_add
    import mult_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw   = {1'b0, acc_in} + (ACC_W+1)'(addend);
        carry = raw[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
        // Once clamped, any later add carries again, so the total stays pinned at all-ones.
        sum   = carry ? '1 : raw[ACC_W-1:0];
`else
        sum   = raw[ACC_W-1:0];
`endif
    end

endmodule : acc_sat_add

// File: rtl/product_accumulator.sv
// Sums a last-terminated burst of multiplier products and presents the sum, term count and overflow.
// Optional PRODUCT_ACC_SATURATE_EN (inside acc_sat_add) clamps the sum instead of wrapping.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    input  logic              acc_clear,
    output logic [ACC_W-1:0]  res_out,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_overflow,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             cnt_sat;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    // ready is held in a flop so it reads 0 during reset and has no path from res_ready.
    assign accept  = prod_valid & ready_q;
    assign cnt_sat = (count_q == CNT_MAX);

    acc_sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .acc_in (acc_q),
        .addend (prod_in),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with readers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (acc_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = prod_last ? HOLD : ACCUM;
                ACCUM:   if (accept && prod_last) state_d = HOLD;
                HOLD:    if (res_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        ready_d = (state_d != HOLD);
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (acc_clear || (state_q == HOLD && res_ready)) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (accept && state_q == IDLE) begin
            acc_d   = ACC_W'(prod_in);
            count_d = CNT_W'(1);
            ovf_d   = 1'b0;
        end else if (accept && state_q == ACCUM) begin
            // A term arriving at a saturated count cannot be represented, so it flags overflow.
            acc_d   = add_sum;
            count_d = cnt_sat ? count_q : count_q + CNT_W'(1);
            ovf_d   = ovf_q | add_carry | cnt_sat;
        end
    end

    always_comb begin
        prod_ready   = ready_q;
        res_valid    = (state_q == HOLD);
        busy         = (state_q != IDLE);
        res_out      = acc_q;
        res_count    = count_q;
        res_overflow = ovf_q;
    end

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Randomized bench for product_accumulator: two instances (default widths; ACC_W=64/CNT_W=2)
// checked against a queue-based burst-sum model.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] d_prod_in;
    logic        d_valid, d_last, d_clear, d_res_ready;
    bit          use_n;

    logic        m_valid_in, n_valid_in, m_clear, n_clear;
    assign m_valid_in = d_valid & ~use_n;
    assign n_valid_in = d_valid & use_n;
    assign m_clear    = d_clear & ~use_n;
    assign n_clear    = d_clear & use_n;

    logic [71:0] m_res_out;
    logic [7:0]  m_res_count;
    logic        m_ovf, m_res_valid, m_ready, m_busy;
    logic [63:0] n_res_out;
    logic [1:0]  n_res_count;
    logic        n_ovf, n_res_valid, n_ready, n_busy;

    product_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_in      (d_prod_in),
        .prod_valid   (m_valid_in),
        .prod_last    (d_last),
        .prod_ready   (m_ready),
        .acc_clear    (m_clear),
        .res_out      (m_res_out),
        .res_count    (m_res_count),
        .res_overflow (m_ovf),
        .res_valid    (m_res_valid),
        .res_ready    (d_res_ready),
        .busy         (m_busy)
    );

    product_accumulator #(.PROD_W(64), .ACC_W(64), .CNT_W(2)) dut_n (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_in      (d_prod_in),
        .prod_valid   (n_valid_in),
        .prod_last    (d_last),
        .prod_ready   (n_ready),
        .acc_clear    (n_clear),
        .res_out      (n_res_out),
        .res_count    (n_res_count),
        .res_overflow (n_ovf),
        .res_valid    (n_res_valid),
        .res_ready    (d_res_ready),
        .busy         (n_busy)
    );

    logic [127:0] o_res;
    logic [7:0]   o_cnt;
    logic         o_ovf, o_valid, o_ready, o_busy;
    assign o_res   = use_n ? {64'd0, n_res_out} : {56'd0, m_res_out};
    assign o_cnt   = use_n ? {6'd0, n_res_count} : m_res_count;
    assign o_ovf   = use_n ? n_ovf : m_ovf;
    assign o_valid = use_n ? n_res_valid : m_res_valid;
    assign o_ready = use_n ? n_ready : m_ready;
    assign o_busy  = use_n ? n_busy : m_busy;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Burst contents for the next run; the model reads the same queue.
    logic [63:0] q[$];

    function automatic void model(output logic [127:0] sum, output int cnt, output bit ovf);
        int           acc_w = use_n ? 64 : 72;
        int           cnt_max = use_n ? 3 : 255;
        logic [127:0] lim = 128'd1 << acc_w;
        sum = '0;
        cnt = 0;
        ovf = 1'b0;
        foreach (q[i]) begin
            sum = sum + {64'd0, q[i]};
            if (sum >= lim) begin
                ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
                sum = lim - 128'd1;
`else
                sum = sum - lim;
`endif
            end
            if (cnt == cnt_max) ovf = 1'b1;
            else cnt++;
        end
    endfunction

    task automatic send(input logic [63:0] p, input logic l);
        int n = 0;
        @(negedge clk);
        d_prod_in = p;
        d_valid   = 1'b1;
        d_last    = l;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    task automatic run_burst(input int stall);
        logic [127:0] e_sum;
        int           e_cnt;
        bit           e_ovf;
        model(e_sum, e_cnt, e_ovf);
        d_res_ready = (stall == 0);
        foreach (q[i]) begin
            if (i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(q[i], i == q.size() - 1);
        end
        @(negedge clk);
        check("res_valid", o_valid, 1);
        check("res_out", o_res, e_sum);
        check("res_count", o_cnt, e_cnt[7:0]);
        check("res_overflow", o_ovf, e_ovf);
        check("ready_in_hold", o_ready, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("hold_valid", o_valid, 1);
            check("hold_out", o_res, e_sum);
            check("hold_count", o_cnt, e_cnt[7:0]);
            check("hold_ready", o_ready, 0);
        end
        d_res_ready = 1'b1;
        @(negedge clk);
        check("drain_valid", o_valid, 0);
        check("drain_busy", o_busy, 0);
        check("drain_out", o_res, 0);
        check("drain_count", o_cnt, 0);
    endtask

    function automatic logic [63:0] rand_prod();
        case ($urandom_range(0, 2))
            0:       return 64'($urandom_range(0, 255));
            1:       return {$urandom, $urandom};
            default: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d_prod_in = '0;
        d_valid = 1'b0;
        d_last = 1'b0;
        d_clear = 1'b0;
        d_res_ready = 1'b0;
        use_n = 1'b0;
        #3;
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_out", o_res, 0);
        check("rst_busy", o_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        q = '{64'h6, 64'hA, 64'h10};
        run_burst(0);
        check("burst3_const", o_res, 0);

        q = '{64'hFFFF_FFFE_0000_0001};
        run_burst(5);

        // Narrow instance: wrap/saturate at 64 bits, then count saturation.
        use_n = 1'b1;
        q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
        run_burst(1);
        q = '{64'h1, 64'h1, 64'h1, 64'h1, 64'h1};
        run_burst(0);
        use_n = 1'b0;

        // Clear mid-burst with a product presented the same cycle.
        send(64'h6, 1'b0);
        send(64'h7, 1'b0);
        @(negedge clk);
        d_clear = 1'b1; d_valid = 1'b1; d_prod_in = 64'h77; d_last = 1'b1;
        check("clr_ready_accum", o_ready, 1);
        @(posedge clk);
        #1;
        d_clear = 1'b0; d_valid = 1'b0; d_last = 1'b0;
        @(negedge clk);
        check("clr_busy", o_busy, 0);
        check("clr_valid", o_valid, 0);
        check("clr_out", o_res, 0);
        check("clr_count", o_cnt, 0);
        q = '{64'h5};
        run_burst(0);

        // Clear while holding a result.
        d_res_ready = 1'b0;
        send(64'h9, 1'b1);
        @(negedge clk);
        check("hclr_valid_pre", o_valid, 1);
        d_clear = 1'b1; d_valid = 1'b1; d_prod_in = 64'h3;
        check("hclr_ready", o_ready, 0);
        @(posedge clk);
        #1;
        d_clear = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        check("hclr_valid", o_valid, 0);
        check("hclr_out", o_res, 0);
        check("hclr_ready_after", o_ready, 1);

        // Asynchronous reset while in HOLD.
        send(64'h1234, 1'b0);
        send(64'h1, 1'b1);
        @(negedge clk);
        check("arst_valid_pre", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", o_valid, 0);
        check("arst_out", o_res, 0);
        check("arst_count", o_cnt, 0);
        check("arst_ovf", o_ovf, 0);
        check("arst_ready", o_ready, 0);
        check("arst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q = '{64'h11, 64'h22};
        run_burst(2);

        for (int b = 0; b < 40; b++) begin
            use_n = ($urandom_range(0, 3) == 0);
            q.delete();
            repeat ($urandom_range(1, 6)) q.push_back(rand_prod());
            run_burst($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_product_accumulator
